// File: rtl/mem_arbiter_if.sv
// Core-side instruction/data ports and backing-memory port of the memory arbiter.
// slave: the arbiter's view. master: the core/memory environment's view.
interface mem_arbiter_if;
    logic [31:0] i_addr;
    logic        i_rd;
    logic [2:0]  i_trd;
    logic [31:0] i_rd_data;
    logic        i_miss;
    logic        i_segfault;

    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic        d_rd;
    logic        d_wr;
    logic [2:0]  d_trd;
    logic [31:0] d_rd_data;
    logic        d_miss;
    logic        d_segfault;

    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rd_data;
    logic        mem_ready;
    logic        mem_err;

    modport slave (
        input  i_addr, i_rd, i_trd,
        input  d_addr, d_wr_data, d_rd, d_wr, d_trd,
        input  mem_rd_data, mem_ready, mem_err,
        output i_rd_data, i_miss, i_segfault,
        output d_rd_data, d_miss, d_segfault,
        output mem_addr, mem_wr_data, mem_rd, mem_wr
    );

    modport master (
        output i_addr, i_rd, i_trd,
        output d_addr, d_wr_data, d_rd, d_wr, d_trd,
        output mem_rd_data, mem_ready, mem_err,
        input  i_rd_data, i_miss, i_segfault,
        input  d_rd_data, d_miss, d_segfault,
        input  mem_addr, mem_wr_data, mem_rd, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported backing memory between the I-fetch and data ports.
// Each side owns a fill buffer; misses are retried by the core while the buffer fills.
module mem_arbiter #(
    parameter int unsigned HOLD_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);
    localparam int unsigned HW = (HOLD_CYC < 1) ? 1 : $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);

    typedef enum logic [1:0] {B_EMPTY, B_PEND, B_INFLT, B_DONE} bstate_t;
    typedef enum logic {F_IDLE, F_BUSY} fstate_t;

    typedef struct packed {
        bstate_t        st;
        logic [31:0]    addr;
        logic [2:0]     trd;
        logic [31:0]    wdata;
        logic           is_wr;
        logic [31:0]    data;
        logic           err;
        logic [HW-1:0]  hold;
    } fill_t;

    // index 0 = instruction side, 1 = data side
    fill_t       fb_q [2];
    fstate_t     fsm_q;
    logic        last_grant_q;
    logic        gnt_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wr_data_q;
    logic        mem_rd_q;
    logic        mem_wr_q;

    logic [1:0]  req;
    logic [1:0]  wr_req;
    logic [1:0]  fault;
    logic [1:0]  hit;
    logic [1:0]  miss;
    logic [1:0]  seg;
    logic [1:0]  capture;
    logic [1:0]  pend;
    logic        gnt_side;
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [2:0]  trd   [2];

    // Same-cycle response decode from buffer state and current requests
    always_comb begin
        req      = {bus.d_rd | bus.d_wr, bus.i_rd};
        wr_req   = {bus.d_wr, 1'b0};
        addr[0]  = bus.i_addr;
        addr[1]  = bus.d_addr;
        trd[0]   = bus.i_trd;
        trd[1]   = bus.d_trd;
        wdata[0] = '0;
        wdata[1] = bus.d_wr ? bus.d_wr_data : '0;
        fault[0] = bus.i_rd && (bus.i_addr[1:0] != 2'b00);
        fault[1] = req[1] && ((bus.d_addr[1:0] != 2'b00) || (bus.d_rd && bus.d_wr));
        hit      = '0;
        miss     = '0;
        seg      = '0;
        capture  = '0;
        rdata[0] = '0;
        rdata[1] = '0;
        for (int s = 0; s < 2; s++) begin
            hit[s]     = req[s] && !fault[s] && (fb_q[s].st == B_DONE) &&
                         (fb_q[s].addr == addr[s]) && (fb_q[s].trd == trd[s]) &&
                         (fb_q[s].is_wr == wr_req[s]);
            miss[s]    = req[s] && !fault[s] && !hit[s];
            seg[s]     = fault[s] || (hit[s] && fb_q[s].err);
            rdata[s]   = (hit[s] && !fb_q[s].is_wr) ? fb_q[s].data : '0;
            // A completed but unclaimed entry may only be stolen once its hold time expires
            capture[s] = miss[s] && ((fb_q[s].st == B_EMPTY) ||
                         ((fb_q[s].st == B_DONE) && (fb_q[s].hold >= HOLD_MAX)));
        end
        pend     = {fb_q[1].st == B_PEND, fb_q[0].st == B_PEND};
        gnt_side = (&pend) ? ~last_grant_q : pend[1];
    end

    // Fill buffers and backing-memory request FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) fb_q[s] <= '0;
            fsm_q         <= F_IDLE;
            last_grant_q  <= 1'b1;
            gnt_q         <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (hit[s]) begin
                    fb_q[s].st   <= B_EMPTY;
                    fb_q[s].hold <= '0;
                end else if (capture[s]) begin
                    fb_q[s].st    <= B_PEND;
                    fb_q[s].addr  <= addr[s];
                    fb_q[s].trd   <= trd[s];
                    fb_q[s].wdata <= wdata[s];
                    fb_q[s].is_wr <= wr_req[s];
                    fb_q[s].hold  <= '0;
                end else if ((fb_q[s].st == B_DONE) && (fb_q[s].hold < HOLD_MAX)) begin
                    fb_q[s].hold <= fb_q[s].hold + 1'b1;
                end
            end

            case (fsm_q)
                F_IDLE: begin
                    if (|pend) begin
                        mem_addr_q          <= fb_q[gnt_side].addr;
                        mem_wr_data_q       <= fb_q[gnt_side].wdata;
                        mem_rd_q            <= !fb_q[gnt_side].is_wr;
                        mem_wr_q            <= fb_q[gnt_side].is_wr;
                        fb_q[gnt_side].st   <= B_INFLT;
                        last_grant_q        <= gnt_side;
                        gnt_q               <= gnt_side;
                        fsm_q               <= F_BUSY;
                    end
                end
                F_BUSY: begin
                    if (bus.mem_ready) begin
                        fb_q[gnt_q].data <= fb_q[gnt_q].is_wr ? '0 : bus.mem_rd_data;
                        fb_q[gnt_q].err  <= bus.mem_err;
                        fb_q[gnt_q].st   <= B_DONE;
                        fb_q[gnt_q].hold <= '0;
                        mem_rd_q         <= 1'b0;
                        mem_wr_q         <= 1'b0;
                        fsm_q            <= F_IDLE;
                    end
                end
                default: fsm_q <= F_IDLE;
            endcase
        end
    end

    assign bus.i_rd_data   = rdata[0];
    assign bus.i_miss      = miss[0];
    assign bus.i_segfault  = seg[0];
    assign bus.d_rd_data   = rdata[1];
    assign bus.d_miss      = miss[1];
    assign bus.d_segfault  = seg[1];
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.mem_rd      = mem_rd_q;
    assign bus.mem_wr      = mem_wr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected core responses and
// memory transactions; a negedge monitor pops and compares them.
module tb_mem_arbiter;
    localparam int unsigned HOLD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.HOLD_CYC(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          tst;
        logic        miss;
        logic        seg;
        logic [31:0] data;
    } core_exp_t;

    typedef struct {
        int          tst;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
    } mem_exp_t;

    core_exp_t q_i[$];
    core_exp_t q_d[$];
    mem_exp_t  q_m[$];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    int tst    = 0;
    int n      = 0;

    logic        auto_resp = 1'b1;
    logic        force_rdy = 1'b0;
    logic [31:0] err_addr  = 32'h200;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] model_data(input logic [31:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return a + 32'h1000_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s test%0d cyc%0d: got %h expected %h", name, tst, cycle, act, exp);
        end
    endtask

    task automatic ei(input logic m, input logic s, input logic [31:0] d);
        core_exp_t e;
        e.tst = tst; e.miss = m; e.seg = s; e.data = d;
        q_i.push_back(e);
    endtask

    task automatic ed(input logic m, input logic s, input logic [31:0] d);
        core_exp_t e;
        e.tst = tst; e.miss = m; e.seg = s; e.data = d;
        q_d.push_back(e);
    endtask

    task automatic em(input int c, input logic [31:0] a, input logic [31:0] w, input logic wr);
        mem_exp_t e;
        e.tst = tst; e.cyc = c; e.addr = a; e.wdata = w; e.wr = wr;
        q_m.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Backing memory: zero-wait responder, store returns junk data that must be dropped
    always @(negedge clk) begin
        if (force_rdy || (auto_resp && (bus.mem_rd || bus.mem_wr))) begin
            bus.mem_ready   = 1'b1;
            bus.mem_rd_data = bus.mem_wr ? 32'hFFFF_FFFF : model_data(bus.mem_addr);
            bus.mem_err     = (bus.mem_addr == err_addr);
        end else begin
            bus.mem_ready   = 1'b0;
            bus.mem_rd_data = 32'h0;
            bus.mem_err     = 1'b0;
        end
    end

    // Monitor
    core_exp_t mon_c;
    mem_exp_t  mon_m;
    logic      prev_act = 1'b0;
    logic      act;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_act = 1'b0;
        end else begin
            if (bus.i_rd) begin
                if (q_i.size() == 0) chk("i_unexpected_req", 32'd1, 32'd0);
                else begin
                    mon_c = q_i.pop_front();
                    chk("i_miss", 32'(bus.i_miss), 32'(mon_c.miss));
                    chk("i_segfault", 32'(bus.i_segfault), 32'(mon_c.seg));
                    chk("i_rd_data", bus.i_rd_data, mon_c.data);
                end
            end else begin
                chk("i_idle_out", bus.i_rd_data | 32'({bus.i_miss, bus.i_segfault}), 32'd0);
            end
            if (bus.d_rd || bus.d_wr) begin
                if (q_d.size() == 0) chk("d_unexpected_req", 32'd1, 32'd0);
                else begin
                    mon_c = q_d.pop_front();
                    chk("d_miss", 32'(bus.d_miss), 32'(mon_c.miss));
                    chk("d_segfault", 32'(bus.d_segfault), 32'(mon_c.seg));
                    chk("d_rd_data", bus.d_rd_data, mon_c.data);
                end
            end else begin
                chk("d_idle_out", bus.d_rd_data | 32'({bus.d_miss, bus.d_segfault}), 32'd0);
            end
            act = bus.mem_rd || bus.mem_wr;
            if (act && !prev_act) begin
                if (q_m.size() == 0) chk("mem_unexpected_txn", bus.mem_addr, 32'hFFFF_FFFF);
                else begin
                    mon_m = q_m.pop_front();
                    chk("mem_cycle", 32'(cycle), 32'(mon_m.cyc));
                    chk("mem_addr", bus.mem_addr, mon_m.addr);
                    chk("mem_wr_data", bus.mem_wr_data, mon_m.wdata);
                    chk("mem_wr", 32'(bus.mem_wr), 32'(mon_m.wr));
                    chk("mem_rd", 32'(bus.mem_rd), 32'(!mon_m.wr));
                end
            end
            prev_act = act;
        end
    end

    task automatic idle_in;
        bus.i_addr = 32'h0; bus.i_rd = 1'b0; bus.i_trd = 3'd0;
        bus.d_addr = 32'h0; bus.d_wr_data = 32'h0; bus.d_rd = 1'b0; bus.d_wr = 1'b0; bus.d_trd = 3'd0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        chk({name, "_mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({name, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({name, "_mem_wr_data"}, bus.mem_wr_data, 32'd0);
        chk({name, "_core"}, 32'({bus.i_miss, bus.i_segfault, bus.d_miss, bus.d_segfault}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tst = 0;
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Simultaneous pair from reset: I granted first
        tst = 2; n = cycle;
        bus.i_rd = 1'b1; bus.i_addr = 32'h10; bus.i_trd = 3'd0;
        bus.d_rd = 1'b1; bus.d_addr = 32'h20; bus.d_trd = 3'd1;
        em(n + 2, 32'h10, 32'h0, 1'b0);
        em(n + 4, 32'h20, 32'h0, 1'b0);
        repeat (3) begin ei(1'b1, 1'b0, 32'h0); ed(1'b1, 1'b0, 32'h0); tick(); end
        ei(1'b0, 1'b0, model_data(32'h10)); ed(1'b1, 1'b0, 32'h0); tick();
        bus.i_rd = 1'b0;
        ed(1'b1, 1'b0, 32'h0); tick();
        ed(1'b0, 1'b0, model_data(32'h20)); tick();
        bus.d_rd = 1'b0; tick();

        // Zero-wait I fetch
        tst = 1; n = cycle;
        bus.i_rd = 1'b1; bus.i_addr = 32'h40; bus.i_trd = 3'd2;
        em(n + 2, 32'h40, 32'h0, 1'b0);
        repeat (3) begin ei(1'b1, 1'b0, 32'h0); tick(); end
        ei(1'b0, 1'b0, 32'hDEADBEEF); tick();
        bus.i_rd = 1'b0; tick();

        // Second pair after an I grant: D granted first
        tst = 2; n = cycle;
        bus.i_rd = 1'b1; bus.i_addr = 32'h14; bus.i_trd = 3'd0;
        bus.d_rd = 1'b1; bus.d_addr = 32'h24; bus.d_trd = 3'd1;
        em(n + 2, 32'h24, 32'h0, 1'b0);
        em(n + 4, 32'h14, 32'h0, 1'b0);
        repeat (3) begin ei(1'b1, 1'b0, 32'h0); ed(1'b1, 1'b0, 32'h0); tick(); end
        ei(1'b1, 1'b0, 32'h0); ed(1'b0, 1'b0, model_data(32'h24)); tick();
        bus.d_rd = 1'b0;
        ei(1'b1, 1'b0, 32'h0); tick();
        ei(1'b0, 1'b0, model_data(32'h14)); tick();
        bus.i_rd = 1'b0; tick();

        // Store
        tst = 3; n = cycle;
        bus.d_wr = 1'b1; bus.d_addr = 32'h100; bus.d_wr_data = 32'h55; bus.d_trd = 3'd5;
        em(n + 2, 32'h100, 32'h55, 1'b1);
        repeat (3) begin ed(1'b1, 1'b0, 32'h0); tick(); end
        ed(1'b0, 1'b0, 32'h0); tick();
        bus.d_wr = 1'b0; bus.d_wr_data = 32'h0; tick();

        // Misalignment and invalid D request: immediate fault, no memory traffic
        tst = 4;
        bus.i_rd = 1'b1; bus.i_addr = 32'h42; bus.i_trd = 3'd0;
        bus.d_rd = 1'b1; bus.d_wr = 1'b1; bus.d_addr = 32'h50;
        ei(1'b0, 1'b1, 32'h0); ed(1'b0, 1'b1, 32'h0); tick();
        bus.i_addr = 32'h43; bus.d_wr = 1'b0; bus.d_addr = 32'h51;
        ei(1'b0, 1'b1, 32'h0); ed(1'b0, 1'b1, 32'h0); tick();
        idle_in(); tick(); tick();
        // Memory error on an aligned fetch
        n = cycle;
        bus.i_rd = 1'b1; bus.i_addr = 32'h200; bus.i_trd = 3'd6;
        em(n + 2, 32'h200, 32'h0, 1'b0);
        repeat (3) begin ei(1'b1, 1'b0, 32'h0); tick(); end
        ei(1'b0, 1'b1, model_data(32'h200)); tick();
        bus.i_rd = 1'b0; tick();

        // Hold then replace an unclaimed result
        tst = 5; n = cycle;
        bus.i_rd = 1'b1; bus.i_addr = 32'h60; bus.i_trd = 3'd1;
        em(n + 2, 32'h60, 32'h0, 1'b0);
        repeat (3) begin ei(1'b1, 1'b0, 32'h0); tick(); end
        bus.i_addr = 32'h80; bus.i_trd = 3'd3;
        em(n + 9, 32'h80, 32'h0, 1'b0);
        repeat (7) begin ei(1'b1, 1'b0, 32'h0); tick(); end
        ei(1'b0, 1'b0, model_data(32'h80)); tick();
        bus.i_addr = 32'h60; bus.i_trd = 3'd1;
        em(n + 13, 32'h60, 32'h0, 1'b0);
        ei(1'b1, 1'b0, 32'h0); tick();
        bus.i_rd = 1'b0;
        repeat (4) tick();

        // Reset while BUSY, then a stale ready pulse
        tst = 6; n = cycle;
        auto_resp = 1'b0;
        bus.d_rd = 1'b1; bus.d_addr = 32'h30; bus.d_trd = 3'd4;
        em(n + 2, 32'h30, 32'h0, 1'b0);
        repeat (3) begin ed(1'b1, 1'b0, 32'h0); tick(); end
        bus.d_rd = 1'b0;
        chk("t6_busy_mem_rd", 32'(bus.mem_rd), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async_reset");
        tick(); tick();
        rst_n = 1'b1;
        force_rdy = 1'b1; tick();
        force_rdy = 1'b0; tick();
        chk_all_zero("t6_after_pulse");
        auto_resp = 1'b1;
        n = cycle;
        bus.d_rd = 1'b1; bus.d_addr = 32'h30; bus.d_trd = 3'd4;
        em(n + 2, 32'h30, 32'h0, 1'b0);
        repeat (3) begin ed(1'b1, 1'b0, 32'h0); tick(); end
        ed(1'b0, 1'b0, model_data(32'h30)); tick();
        bus.d_rd = 1'b0;
        repeat (2) tick();

        tst = 7;
        chk("queues_drained", 32'(q_i.size() + q_d.size() + q_m.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
